asrv32_decode_queue: RTL and testbench
======================================

// Module: asrv32_decode_queue
// PURPOSE
//  Parametrised ID stage: decodes RV32I (+optional M) instructions, applies stricter illegal-instruction checks, and buffers decoded bundles.
//  Sits between fetch and execute. Uses a valid/ready handshake on both sides and flushes on redirect.
//  The queue of DEPTH decoded entries absorbs execute back-pressure without stalling fetch combinationally.
// PARAMETERS
//  DEPTH     2  decoded-bundle queue entries (>=1, any integer)
//  ENABLE_M  0  1: decode MUL/DIV/REM (funct7=0000001); 0: those encodings raise ILLEGAL
//  CHECK_F7  1  1: non-canonical funct7 / shamt upper bits raise ILLEGAL; 0: ignore funct7 except bit30
// PORTS
//  i_clk          in   1   clock
//  i_rst_n        in   1   synchronous active-low reset
//  i_valid        in   1   fetch presents i_inst/i_pc
//  o_ready        out  1   queue can accept (count < DEPTH)
//  i_inst         in   32  instruction word
//  i_pc           in   32  instruction PC
//  o_rs1_addr     out  5   i_inst[19:15], combinational, to regfile
//  o_rs2_addr     out  5   i_inst[24:20], combinational, to regfile
//  o_valid        out  1   head entry valid
//  i_ready        in   1   execute consumes head this cycle
//  o_pc           out  32  head PC
//  o_rs1/rs2/rd   out  5   head register addresses
//  o_imm          out  32  head sign-extended immediate
//  o_funct3       out  3   head funct3
//  o_opcode       out  `OPCODE_WIDTH (11)  one-hot opcode class
//  o_alu_op       out  `ALU_WIDTH (14)     one-hot ALU op
//  o_mdu_op       out  8   one-hot MUL,MULH,MULHSU,MULHU,DIV,DIVU,REM,REMU (funct3 order); 0 if ENABLE_M=0
//  o_exception    out  `EXCEPTION_WIDTH (4) ILLEGAL,ECALL,EBREAK,MRET
//  i_flush        in   1   discard all entries and same-cycle input
//  o_count        out  $clog2(DEPTH+1)  occupancy
// BEHAVIOUR
//  Reset (i_rst_n=0 at posedge): head/tail pointers and count=0, o_valid=0. All registered bundle fields read 0.
//  Push = i_valid&&o_ready&&!i_flush. Pop = o_valid&&i_ready&&!i_flush. Both can occur in one cycle; count is unchanged.
//  o_ready = (count<DEPTH), registered-state based. No combinational path from i_ready to o_ready.
//  Latency: an accepted instruction appears at the head one cycle later if the queue was empty. FIFO order is strict.
//  Pointers wrap at DEPTH-1 to 0. Non-power-of-2 DEPTH must work.
//  i_flush has priority: next cycle count=0, o_valid=0. Push and pop that cycle are ignored. Flush during reset: reset wins.
//  Head outputs are driven from the queue storage. When o_valid=0, fields hold the last value (don't care).
//  Decode (combinational on i_inst, captured on push):
//   - opcode one-hot per header OPCODE_* compare. Immediate per type: I/LOAD/JALR, S, B, J, U(LUI/AUIPC), SYSTEM/FENCE zero-extended.
//   - RTYPE/ITYPE: funct3 selects op. RTYPE funct3=000 uses bit30 for ADD/SUB. funct3=101 uses bit30 for SRL/SRA.
//   - BRANCH: EQ,NEQ,LT->SLT,GE,LTU->SLTU,GEU. Unused funct3 (010,011) raises ILLEGAL.
//   - All other opcodes: ADD.
//   - RTYPE funct7=0000001 with ENABLE_M=1: o_mdu_op set, o_alu_op=0.
//  ILLEGAL when any of the following holds:
//   - i_inst[1:0]!=11
//   - unknown opcode
//   - ITYPE shift with i_inst[25]=1
//   - CHECK_F7=1: RTYPE funct7 not in {0000000; 0100000 only for funct3 000/101; 0000001 only if ENABLE_M}
//   - CHECK_F7=1: SLLI/SRLI/SRAI with i_inst[31:25] not in {0000000; 0100000 for SRAI}
//   - M encoding with ENABLE_M=0
//  SYSTEM funct3=000: i_inst[31:20]=000 sets ECALL, =001 sets EBREAK, =302 sets MRET, others set ILLEGAL. rs1/rd must be 0, else ILLEGAL.
//  Exactly one exception bit at most. ILLEGAL suppresses ECALL/EBREAK/MRET.
// TESTING
//  addi x1,x0,5 (0x00500093), i_ready=1 -> next cycle o_valid=1, ITYPE, ADD, o_imm=5, o_rd=1, exception=0
//  sub x3,x1,x2 (0x402081B3) -> RTYPE, SUB. 0x602081B3 with CHECK_F7=1 -> ILLEGAL
//  mul x5,x6,x7 (0x027302B3): ENABLE_M=1 -> o_mdu_op=00000001, alu_op=0. ENABLE_M=0 -> ILLEGAL
//  DEPTH=3, i_ready=0, push 4 back-to-back -> o_ready=0 after 3rd. Release i_ready -> 3 entries drain in order, o_count 3->0
//  Queue holds 2 entries; assert i_flush with i_valid=1 -> next cycle o_valid=0, o_count=0, flushed input never seen
//  ecall 0x00000073 -> ECALL. mret 0x30200073 -> MRET. slli x1,x1,32 (0x02009093) -> ILLEGAL. Reset mid-stream -> o_valid=0

Source files
------------

// File: rtl/asrv32_decode_queue.sv
`default_nettype none
// ============================================================================
// Module      : asrv32_decode_queue
// Description : RV32I(+M) decode stage with strict illegal checks feeding a
//               DEPTH-entry FIFO of decoded bundles toward execute.
// Revision    : 1.0 - initial release
// ============================================================================
module asrv32_decode_queue #(
    parameter int DEPTH    = 2,
    parameter bit ENABLE_M = 1'b0,
    parameter bit CHECK_F7 = 1'b1
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_valid,
    output logic                       o_ready,
    input  logic [31:0]                i_inst,
    input  logic [31:0]                i_pc,
    output logic [4:0]                 o_rs1_addr,
    output logic [4:0]                 o_rs2_addr,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic [31:0]                o_pc,
    output logic [4:0]                 o_rs1,
    output logic [4:0]                 o_rs2,
    output logic [4:0]                 o_rd,
    output logic [31:0]                o_imm,
    output logic [2:0]                 o_funct3,
    output logic [10:0]                o_opcode,
    output logic [13:0]                o_alu_op,
    output logic [7:0]                 o_mdu_op,
    output logic [3:0]                 o_exception,
    input  logic                       i_flush,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] c_DEPTH = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] c_LAST  = PTR_W'(DEPTH - 1);

    localparam int c_OP_RTYPE = 0, c_OP_ITYPE = 1, c_OP_LOAD = 2, c_OP_STORE = 3;
    localparam int c_OP_BRANCH = 4, c_OP_JAL = 5, c_OP_JALR = 6, c_OP_LUI = 7;
    localparam int c_OP_AUIPC = 8, c_OP_SYSTEM = 9, c_OP_FENCE = 10;
    localparam int c_ALU_ADD = 0, c_ALU_SUB = 1, c_ALU_SLT = 2, c_ALU_SLTU = 3;
    localparam int c_ALU_XOR = 4, c_ALU_OR = 5, c_ALU_AND = 6, c_ALU_SLL = 7;
    localparam int c_ALU_SRL = 8, c_ALU_SRA = 9, c_ALU_EQ = 10, c_ALU_NEQ = 11;
    localparam int c_ALU_GE = 12, c_ALU_GEU = 13;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [2:0]  funct3;
        logic [10:0] opcode;
        logic [13:0] alu_op;
        logic [7:0]  mdu_op;
        logic [3:0]  exception;
    } bundle_t;

    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [10:0] w_opc;
    logic [31:0] w_imm;
    logic [13:0] w_alu;
    logic [7:0]  w_mdu;
    logic        w_is_m, w_is_shift_i, w_f7_ok, w_shamt_ok;
    logic        w_priv, w_ecall, w_ebreak, w_mret, w_sys_bad, w_br_bad, w_illegal;
    bundle_t     w_bundle;

    assign w_f3       = i_inst[14:12];
    assign w_f7       = i_inst[31:25];
    assign o_rs1_addr = i_inst[19:15];
    assign o_rs2_addr = i_inst[24:20];

    always_comb begin
        w_opc               = '0;
        w_opc[c_OP_RTYPE]   = (i_inst[6:0] == 7'b0110011);
        w_opc[c_OP_ITYPE]   = (i_inst[6:0] == 7'b0010011);
        w_opc[c_OP_LOAD]    = (i_inst[6:0] == 7'b0000011);
        w_opc[c_OP_STORE]   = (i_inst[6:0] == 7'b0100011);
        w_opc[c_OP_BRANCH]  = (i_inst[6:0] == 7'b1100011);
        w_opc[c_OP_JAL]     = (i_inst[6:0] == 7'b1101111);
        w_opc[c_OP_JALR]    = (i_inst[6:0] == 7'b1100111);
        w_opc[c_OP_LUI]     = (i_inst[6:0] == 7'b0110111);
        w_opc[c_OP_AUIPC]   = (i_inst[6:0] == 7'b0010111);
        w_opc[c_OP_SYSTEM]  = (i_inst[6:0] == 7'b1110011);
        w_opc[c_OP_FENCE]   = (i_inst[6:0] == 7'b0001111);
    end

    always_comb begin
        w_imm = '0;
        if (w_opc[c_OP_ITYPE] || w_opc[c_OP_LOAD] || w_opc[c_OP_JALR])
            w_imm = {{20{i_inst[31]}}, i_inst[31:20]};
        else if (w_opc[c_OP_STORE])
            w_imm = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
        else if (w_opc[c_OP_BRANCH])
            w_imm = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
        else if (w_opc[c_OP_JAL])
            w_imm = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};
        else if (w_opc[c_OP_LUI] || w_opc[c_OP_AUIPC])
            w_imm = {i_inst[31:12], 12'b0};
        else if (w_opc[c_OP_SYSTEM] || w_opc[c_OP_FENCE])
            w_imm = {20'b0, i_inst[31:20]};
    end

    assign w_is_m       = w_opc[c_OP_RTYPE] && (w_f7 == 7'b0000001);
    assign w_is_shift_i = w_opc[c_OP_ITYPE] && (w_f3[1:0] == 2'b01);

    always_comb begin
        w_alu    = '0;
        w_mdu    = '0;
        w_br_bad = 1'b0;
        if (w_opc[c_OP_RTYPE] || w_opc[c_OP_ITYPE]) begin
            case (w_f3)
                3'b000: w_alu[(w_opc[c_OP_RTYPE] && i_inst[30]) ? c_ALU_SUB : c_ALU_ADD] = 1'b1;
                3'b001: w_alu[c_ALU_SLL]  = 1'b1;
                3'b010: w_alu[c_ALU_SLT]  = 1'b1;
                3'b011: w_alu[c_ALU_SLTU] = 1'b1;
                3'b100: w_alu[c_ALU_XOR]  = 1'b1;
                3'b101: w_alu[i_inst[30] ? c_ALU_SRA : c_ALU_SRL] = 1'b1;
                3'b110: w_alu[c_ALU_OR]   = 1'b1;
                default: w_alu[c_ALU_AND] = 1'b1;
            endcase
            if (ENABLE_M && w_is_m) begin
                w_alu        = '0;
                w_mdu[w_f3]  = 1'b1;
            end
        end else if (w_opc[c_OP_BRANCH]) begin
            case (w_f3)
                3'b000: w_alu[c_ALU_EQ]   = 1'b1;
                3'b001: w_alu[c_ALU_NEQ]  = 1'b1;
                3'b100: w_alu[c_ALU_SLT]  = 1'b1;
                3'b101: w_alu[c_ALU_GE]   = 1'b1;
                3'b110: w_alu[c_ALU_SLTU] = 1'b1;
                3'b111: w_alu[c_ALU_GEU]  = 1'b1;
                default: w_br_bad         = 1'b1;
            endcase
        end else begin
            w_alu[c_ALU_ADD] = 1'b1;
        end
    end

    assign w_f7_ok    = (w_f7 == 7'b0000000) ||
                        ((w_f7 == 7'b0100000) && ((w_f3 == 3'b000) || (w_f3 == 3'b101))) ||
                        ((w_f7 == 7'b0000001) && ENABLE_M);
    assign w_shamt_ok = (w_f7 == 7'b0000000) || ((w_f7 == 7'b0100000) && (w_f3 == 3'b101));

    // Privileged SYSTEM forms need rs1=rd=0 and one of three known imm12 codes.
    assign w_priv    = w_opc[c_OP_SYSTEM] && (w_f3 == 3'b000);
    assign w_ecall   = w_priv && (i_inst[31:20] == 12'h000);
    assign w_ebreak  = w_priv && (i_inst[31:20] == 12'h001);
    assign w_mret    = w_priv && (i_inst[31:20] == 12'h302);
    assign w_sys_bad = w_priv && (!(w_ecall || w_ebreak || w_mret) ||
                                  (i_inst[19:15] != 5'd0) || (i_inst[11:7] != 5'd0));

    assign w_illegal = (i_inst[1:0] != 2'b11) || (w_opc == '0) ||
                       (w_is_shift_i && i_inst[25]) ||
                       (CHECK_F7 && w_opc[c_OP_RTYPE] && !w_f7_ok) ||
                       (CHECK_F7 && w_is_shift_i && !w_shamt_ok) ||
                       (w_is_m && !ENABLE_M) || w_br_bad || w_sys_bad;

    always_comb begin
        w_bundle           = '0;
        w_bundle.pc        = i_pc;
        w_bundle.rs1       = i_inst[19:15];
        w_bundle.rs2       = i_inst[24:20];
        w_bundle.rd        = i_inst[11:7];
        w_bundle.imm       = w_imm;
        w_bundle.funct3    = w_f3;
        w_bundle.opcode    = w_opc;
        w_bundle.alu_op    = w_alu;
        w_bundle.mdu_op    = w_mdu;
        w_bundle.exception = {w_mret && !w_illegal, w_ebreak && !w_illegal,
                              w_ecall && !w_illegal, w_illegal};
    end

    bundle_t          r_mem [DEPTH];
    logic [PTR_W-1:0] r_head, r_tail;
    logic [CNT_W-1:0] r_count;
    logic             w_push, w_pop;

    assign o_ready = (r_count != c_DEPTH);
    assign o_valid = (r_count != '0);
    assign o_count = r_count;
    assign w_push  = i_valid && o_ready && !i_flush;
    assign w_pop   = o_valid && i_ready && !i_flush;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_tail] <= w_bundle;
                r_tail        <= (r_tail == c_LAST) ? '0 : r_tail + 1'b1;
            end
            if (w_pop) r_head <= (r_head == c_LAST) ? '0 : r_head + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;
        end
    end

    assign o_pc        = r_mem[r_head].pc;
    assign o_rs1       = r_mem[r_head].rs1;
    assign o_rs2       = r_mem[r_head].rs2;
    assign o_rd        = r_mem[r_head].rd;
    assign o_imm       = r_mem[r_head].imm;
    assign o_funct3    = r_mem[r_head].funct3;
    assign o_opcode    = r_mem[r_head].opcode;
    assign o_alu_op    = r_mem[r_head].alu_op;
    assign o_mdu_op    = r_mem[r_head].mdu_op;
    assign o_exception = r_mem[r_head].exception;
endmodule
`default_nettype wire

// File: tb/tb_asrv32_decode_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_asrv32_decode_queue
// Description : Scoreboard bench for asrv32_decode_queue (DEPTH=3, M on) plus
//               a second instance (M off, funct7 checks off).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_asrv32_decode_queue;
    localparam logic [10:0] OP_R = 11'h001, OP_I = 11'h002, OP_ST = 11'h008, OP_BR = 11'h010;
    localparam logic [10:0] OP_JAL = 11'h020, OP_LUI = 11'h080, OP_SYS = 11'h200;
    localparam logic [13:0] A_ADD = 14'h0001, A_SUB = 14'h0002, A_SRA = 14'h0200, A_EQ = 14'h0400;
    localparam logic [3:0]  X_ILL = 4'h1, X_ECALL = 4'h2, X_EBREAK = 4'h4, X_MRET = 4'h8;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [31:0] imm;
        logic [10:0] opc;
        logic [13:0] alu;
        logic [7:0]  mdu;
        logic [3:0]  exc;
        bit          exc_only;
        bit          imm_dc;
    } sb_t;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        i_valid = 1'b0, i_ready = 1'b0, i_flush = 1'b0;
    logic [31:0] i_inst = '0, i_pc = '0;
    logic        o_ready, o_valid;
    logic [4:0]  o_rs1_addr, o_rs2_addr, o_rs1, o_rs2, o_rd;
    logic [31:0] o_pc, o_imm;
    logic [2:0]  o_funct3;
    logic [10:0] o_opcode;
    logic [13:0] o_alu_op;
    logic [7:0]  o_mdu_op;
    logic [3:0]  o_exception;
    logic [1:0]  o_count;

    logic        b_valid = 1'b0;
    logic [31:0] b_inst = '0;
    logic        b_o_ready, b_o_valid;
    logic [4:0]  b_rs1_addr, b_rs2_addr, b_rs1, b_rs2, b_rd;
    logic [31:0] b_pc, b_imm;
    logic [2:0]  b_funct3;
    logic [10:0] b_opcode;
    logic [13:0] b_alu_op;
    logic [7:0]  b_mdu_op;
    logic [3:0]  b_exception;
    logic [1:0]  b_count;

    int  n_err = 0, n_chk = 0;
    sb_t exp_q[$];
    sb_t cur, mon_e;
    sb_t tv[16];

    always #5 clk = ~clk;

    asrv32_decode_queue #(.DEPTH(3), .ENABLE_M(1'b1), .CHECK_F7(1'b1)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_inst(i_inst), .i_pc(i_pc), .o_rs1_addr(o_rs1_addr), .o_rs2_addr(o_rs2_addr),
        .o_valid(o_valid), .i_ready(i_ready), .o_pc(o_pc), .o_rs1(o_rs1), .o_rs2(o_rs2),
        .o_rd(o_rd), .o_imm(o_imm), .o_funct3(o_funct3), .o_opcode(o_opcode),
        .o_alu_op(o_alu_op), .o_mdu_op(o_mdu_op), .o_exception(o_exception),
        .i_flush(i_flush), .o_count(o_count)
    );

    asrv32_decode_queue #(.DEPTH(2), .ENABLE_M(1'b0), .CHECK_F7(1'b0)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(b_valid), .o_ready(b_o_ready),
        .i_inst(b_inst), .i_pc(32'h0), .o_rs1_addr(b_rs1_addr), .o_rs2_addr(b_rs2_addr),
        .o_valid(b_o_valid), .i_ready(1'b1), .o_pc(b_pc), .o_rs1(b_rs1), .o_rs2(b_rs2),
        .o_rd(b_rd), .o_imm(b_imm), .o_funct3(b_funct3), .o_opcode(b_opcode),
        .o_alu_op(b_alu_op), .o_mdu_op(b_mdu_op), .o_exception(b_exception),
        .i_flush(1'b0), .o_count(b_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic sb_t mk(input logic [31:0] inst, input logic [4:0] rd, rs1, rs2,
                               input logic [2:0] f3, input logic [31:0] imm,
                               input logic [10:0] opc, input logic [13:0] alu,
                               input logic [7:0] mdu, input logic [3:0] exc,
                               input bit exc_only, input bit imm_dc);
        sb_t e;
        e.inst = inst; e.pc = '0; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2; e.f3 = f3;
        e.imm = imm; e.opc = opc; e.alu = alu; e.mdu = mdu; e.exc = exc;
        e.exc_only = exc_only; e.imm_dc = imm_dc;
        return e;
    endfunction

    // Pop-compare first, then record any push accepted at the coming edge.
    always @(negedge clk) begin
        if (rst_n && !i_flush) begin
            if (o_valid && i_ready) begin
                if (exp_q.size() == 0) check("pop_unexpected", 32'(o_pc), 32'hFFFF_FFFF);
                else begin
                    mon_e = exp_q.pop_front();
                    check("exc", 32'(o_exception), 32'(mon_e.exc));
                    check("pc", o_pc, mon_e.pc);
                    if (!mon_e.exc_only) begin
                        check("rd", 32'(o_rd), 32'(mon_e.rd));
                        check("rs1", 32'(o_rs1), 32'(mon_e.rs1));
                        check("rs2", 32'(o_rs2), 32'(mon_e.rs2));
                        check("funct3", 32'(o_funct3), 32'(mon_e.f3));
                        check("opcode", 32'(o_opcode), 32'(mon_e.opc));
                        check("alu_op", 32'(o_alu_op), 32'(mon_e.alu));
                        check("mdu_op", 32'(o_mdu_op), 32'(mon_e.mdu));
                        if (!mon_e.imm_dc) check("imm", o_imm, mon_e.imm);
                    end
                end
            end
            if (i_valid && o_ready) exp_q.push_back(cur);
        end
    end

    task automatic send(input sb_t e);
        bit ok;
        int k = 0;
        i_valid = 1'b1; i_inst = e.inst; i_pc = e.pc; cur = e;
        #1 check("rs1_addr", 32'(o_rs1_addr), 32'(e.inst[19:15]));
        do begin
            @(negedge clk); ok = o_ready;
            @(posedge clk); #1; k++;
        end while (!ok && k < 200);
        if (!ok) check("send_timeout", 32'(ok), 32'd1);
        i_valid = 1'b0;
    endtask

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        tv[0]  = mk(32'h00500093, 1, 0, 5, 0, 32'h5, OP_I, A_ADD, 0, 0, 0, 0);
        tv[1]  = mk(32'h402081B3, 3, 1, 2, 0, 0, OP_R, A_SUB, 0, 0, 0, 1);
        tv[2]  = mk(32'h602081B3, 0, 0, 0, 0, 0, 0, 0, 0, X_ILL, 1, 1);
        tv[3]  = mk(32'h027302B3, 5, 6, 7, 0, 0, OP_R, 0, 8'h01, 0, 0, 1);
        tv[4]  = mk(32'h00000073, 0, 0, 0, 0, 0, OP_SYS, A_ADD, 0, X_ECALL, 0, 0);
        tv[5]  = mk(32'h30200073, 0, 0, 2, 0, 32'h302, OP_SYS, A_ADD, 0, X_MRET, 0, 0);
        tv[6]  = mk(32'h02009093, 0, 0, 0, 0, 0, 0, 0, 0, X_ILL, 1, 1);
        tv[7]  = mk(32'h123452B7, 5, 8, 3, 5, 32'h12345000, OP_LUI, A_ADD, 0, 0, 0, 0);
        tv[8]  = mk(32'hFE208CE3, 25, 1, 2, 0, 32'hFFFFFFF8, OP_BR, A_EQ, 0, 0, 0, 0);
        tv[9]  = mk(32'h403150B3, 1, 2, 3, 5, 0, OP_R, A_SRA, 0, 0, 0, 1);
        tv[10] = mk(32'hFE20AE23, 28, 1, 2, 2, 32'hFFFFFFFC, OP_ST, A_ADD, 0, 0, 0, 0);
        tv[11] = mk(32'h001000EF, 1, 0, 1, 0, 32'h800, OP_JAL, A_ADD, 0, 0, 0, 0);
        tv[12] = mk(32'h0020A063, 0, 0, 0, 0, 0, 0, 0, 0, X_ILL, 1, 1);
        tv[13] = mk(32'h00500090, 0, 0, 0, 0, 0, 0, 0, 0, X_ILL, 1, 1);
        tv[14] = mk(32'h000000F3, 0, 0, 0, 0, 0, 0, 0, 0, X_ILL, 1, 1);
        tv[15] = mk(32'h00100073, 0, 0, 1, 0, 32'h1, OP_SYS, A_ADD, 0, X_EBREAK, 0, 0);
        for (int i = 0; i < 16; i++) tv[i].pc = 32'h1000 + 32'(i * 4);

        cyc(3); rst_n = 1'b1;
        @(negedge clk);
        check("rst_valid", 32'(o_valid), 0);
        check("rst_count", 32'(o_count), 0);
        check("rst_ready", 32'(o_ready), 1);
        check("rst_pc", o_pc, 0);
        check("rst_opcode", 32'(o_opcode), 0);
        @(posedge clk); #1;

        // Streaming decode with execute always ready.
        i_ready = 1'b1;
        for (int i = 0; i < 16; i++) send(tv[i]);
        cyc(4);
        check("stream_drained", 32'(exp_q.size()), 0);

        // Back-pressure: fill three, fourth is refused, then drain in order.
        i_ready = 1'b0;
        send(tv[0]); send(tv[1]); send(tv[8]);
        i_valid = 1'b1; i_inst = tv[9].inst; i_pc = tv[9].pc; cur = tv[9];
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("full_ready", 32'(o_ready), 0);
            check("full_count", 32'(o_count), 3);
            @(posedge clk); #1;
        end
        i_valid = 1'b0; i_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("drain_count", 32'(o_count), 32'(3 - k));
            @(posedge clk); #1;
        end
        check("drain_empty", 32'(exp_q.size()), 0);

        // Flush with a same-cycle input that must never appear.
        i_ready = 1'b0;
        send(tv[7]); send(tv[10]);
        i_valid = 1'b1; i_inst = tv[11].inst; i_pc = tv[11].pc; cur = tv[11]; i_flush = 1'b1;
        @(posedge clk); #1;
        i_flush = 1'b0; i_valid = 1'b0; exp_q.delete();
        @(negedge clk);
        check("flush_valid", 32'(o_valid), 0);
        check("flush_count", 32'(o_count), 0);
        i_ready = 1'b1;
        cyc(3);
        check("flush_nothing", 32'(o_valid), 0);
        send(tv[15]);
        cyc(3);
        check("post_flush_empty", 32'(exp_q.size()), 0);

        // Reset mid-stream, with flush and valid also asserted.
        i_ready = 1'b0;
        send(tv[4]); send(tv[5]);
        rst_n = 1'b0; i_flush = 1'b1;
        i_valid = 1'b1; i_inst = tv[6].inst; i_pc = tv[6].pc; cur = tv[6];
        @(posedge clk); #1;
        rst_n = 1'b1; i_flush = 1'b0; i_valid = 1'b0; exp_q.delete();
        @(negedge clk);
        check("mrst_valid", 32'(o_valid), 0);
        check("mrst_count", 32'(o_count), 0);
        check("mrst_pc", o_pc, 0);
        check("mrst_imm", o_imm, 0);
        check("mrst_exc", 32'(o_exception), 0);
        @(posedge clk); #1;
        i_ready = 1'b1;

        // Second instance: M disabled, funct7 checking relaxed.
        b_valid = 1'b1; b_inst = 32'h027302B3;
        @(posedge clk); #1; b_valid = 1'b0;
        @(negedge clk);
        check("b_mul_valid", 32'(b_o_valid), 1);
        check("b_mul_exc", 32'(b_exception), 32'(X_ILL));
        @(posedge clk); #1;
        b_valid = 1'b1; b_inst = 32'h602081B3;
        @(posedge clk); #1; b_valid = 1'b0;
        @(negedge clk);
        check("b_f7_exc", 32'(b_exception), 0);
        check("b_f7_alu", 32'(b_alu_op), 32'(A_SUB));
        check("b_f7_opc", 32'(b_opcode), 32'(OP_R));
        @(posedge clk); #1;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
